// File: rtl/wb_lsu_master.sv
// Load/store bus master: turns CPU byte/half/word requests into single-word
// stb/ack bus cycles, with read-modify-write for sub-word stores.
module wb_lsu_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        busy,
    output logic        err_align,
    output logic        err_bus,
    output logic [31:0] dat_o,
    output logic [31:0] adr_o,
    output logic        we_o,
    output logic        stb_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic [2:0]  state_dbg
);

    // Bus handshake: a beat completes on a rising edge where stb_o and ack_i
    // are both high; stb_o, adr_o, we_o and dat_o stay stable until then.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALERR = 3'd1,
        S_RD    = 3'd2,
        S_RDCAP = 3'd3,
        S_WR    = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [15:0] wdata_q;
    logic [7:0]  cnt;
    logic        err_a_q, err_b_q;
    logic        misaligned;
    logic        timed_out;
    logic [4:0]  lane_sh;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign state_dbg = state;
    assign adr_o     = {addr_q[31:2], 2'b00};
    assign timed_out = (cnt == TMAX);
    assign lane_sh   = {addr_q[1:0], 3'b000};

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (misaligned)                 state_nx = S_ALERR;
                    else if (we && size == 2'b10)   state_nx = S_WR;
                    else                            state_nx = S_RD;
                end
            end
            S_ALERR: state_nx = S_FIN;
            S_RD: begin
                if (ack_i)          state_nx = S_RDCAP;
                else if (timed_out) state_nx = S_FIN;
            end
            S_RDCAP: state_nx = we_q ? S_WR : S_FIN;
            S_WR: begin
                if (ack_i || timed_out) state_nx = S_FIN;
            end
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stb_o     = (state == S_RD) || (state == S_WR);
        we_o      = (state == S_WR);
        done      = (state == S_FIN);
        busy      = (state != S_IDLE);
        err_align = (state == S_FIN) && err_a_q;
        err_bus   = (state == S_FIN) && err_b_q;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        lane_byte = dat_i[lane_sh +: 8];
        lane_half = addr_q[1] ? dat_i[31:16] : dat_i[15:0];
        load_ext  = dat_i;
        merged    = dat_i;
        case (size_q)
            2'b00: begin
                load_ext = {{24{sext_q & lane_byte[7]}}, lane_byte};
                merged[lane_sh +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = {{16{sext_q & lane_half[15]}}, lane_half};
                if (addr_q[1]) merged[31:16] = wdata_q;
                else           merged[15:0]  = wdata_q;
            end
            default: begin
                load_ext = dat_i;
                merged   = dat_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sext_q  <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            dat_o   <= '0;
            cnt     <= '0;
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;
        end else begin
            // Counter only runs while strobing; RDCAP clears it before WR.
            if (state == S_RD || state == S_WR) cnt <= cnt + 8'd1;
            else                                cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sext;
                        wdata_q <= wdata[15:0];
                        err_a_q <= 1'b0;
                        err_b_q <= 1'b0;
                        if (we && size == 2'b10) dat_o <= wdata;
                    end
                end
                S_ALERR: err_a_q <= 1'b1;
                S_RD, S_WR: begin
                    if (!ack_i && timed_out) err_b_q <= 1'b1;
                end
                S_RDCAP: begin
                    if (we_q) dat_o <= merged;
                    else      rdata <= load_ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master with a small word memory slave.
module tb_wb_lsu_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, busy, err_align, err_bus;
    logic [31:0] dat_o, adr_o;
    logic        we_o, stb_o;
    logic [31:0] dat_i = '0;
    logic        ack_i;
    logic [2:0]  state_dbg;

    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    logic        poke_en = 1'b0;
    logic [3:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [31:0] mem [0:15];

    int n_cmp = 0;
    int n_err = 0;
    int lat, stb_cyc, wr_cyc;
    logic [31:0] last_adr, last_wdat;
    logic ea, eb;

    always #5 clk = ~clk;

    assign ack_i = (stb_o & ack_en) | ack_force;

    wb_lsu_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
        .err_align(err_align), .err_bus(err_bus), .dat_o(dat_o), .adr_o(adr_o),
        .we_o(we_o), .stb_o(stb_o), .dat_i(dat_i), .ack_i(ack_i),
        .state_dbg(state_dbg)
    );

    // Slave: registers read data on the ack edge, writes on the ack edge.
    always @(posedge clk) begin
        if (poke_en) mem[poke_idx] <= poke_val;
        else if (stb_o && ack_i) begin
            if (we_o) mem[adr_o[5:2]] <= dat_o;
            else      dat_i <= mem[adr_o[5:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk);
        #1 poke_en = 1'b0;
    endtask

    // lat = rising edges from the accepting edge until done is seen high.
    task automatic run_req(input logic w, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sext = s; addr = a; wdata = d;
        stb_cyc = 0; wr_cyc = 0; last_adr = '0; last_wdat = '0; ea = 1'b0; eb = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1;
        while (lat < 200) begin
            @(negedge clk);
            if (stb_o) begin
                stb_cyc++;
                last_adr = adr_o;
                if (we_o) begin wr_cyc++; last_wdat = dat_o; end
            end
            if (done) begin ea = err_align; eb = err_bus; break; end
            @(posedge clk);
            lat++;
        end
        if (lat >= 200) check("done_timeout", 32'(lat), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'hCAFEF00D;
        #12;
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_adr", adr_o, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Word load
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("wload_lat", 32'(lat), 32'd3);
        check("wload_stb", 32'(stb_cyc), 32'd1);
        check("wload_adr", last_adr, 32'h10);
        check("wload_data", rdata, 32'hDEADBEEF);
        check("wload_err", {30'h0, ea, eb}, 32'h0);

        run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        check("lb_s13", rdata, 32'hFFFFFFDE);
        run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        check("lbu_13", rdata, 32'h000000DE);
        run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
        check("lh_s10", rdata, 32'hFFFFBEEF);
        check("lh_lat", 32'(lat), 32'd3);
        run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("lhu_12", rdata, 32'h0000DEAD);
        run_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        check("lb_s11", rdata, 32'hFFFFFFBE);
        run_req(1'b0, 2'b00, 1'b1, 32'h14, 32'h0);
        check("lb_s14", rdata, 32'h0000000D);

        // Byte store read-modify-write
        poke(4'd4, 32'h11223344);
        run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA);
        check("sb_lat", 32'(lat), 32'd4);
        check("sb_stb", 32'(stb_cyc), 32'd2);
        check("sb_wr", 32'(wr_cyc), 32'd1);
        check("sb_dat", last_wdat, 32'h1122AA44);
        check("sb_rdata_kept", rdata, 32'h0000000D);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("sb_reread", rdata, 32'h1122AA44);

        // Halfword store upper lane
        run_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF5A5A);
        check("sh_dat", last_wdat, 32'h5A5AF00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
        check("sh_reread", rdata, 32'h5A5AF00D);

        // Word store
        run_req(1'b1, 2'b10, 1'b0, 32'h18, 32'h01234567);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_dat", last_wdat, 32'h01234567);
        run_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        check("sw_reread", rdata, 32'h01234567);

        // Misaligned accesses
        run_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF);
        check("mis_lat", 32'(lat), 32'd2);
        check("mis_stb", 32'(stb_cyc), 32'd0);
        check("mis_flags", {30'h0, ea, eb}, 32'h2);
        check("mis_rdata_kept", rdata, 32'h01234567);
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("mis_mem", rdata, 32'h1122AA44);
        run_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        check("mis_half", {30'h0, ea, eb}, 32'h2);
        run_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        check("rsv_size", {30'h0, ea, eb}, 32'h2);
        check("rsv_stb", 32'(stb_cyc), 32'd0);

        // Stray ack while idle
        @(negedge clk); ack_force = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stray_ack_busy", 32'(busy), 32'd0);
        ack_force = 1'b0;

        // Bus timeout
        ack_en = 1'b0;
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("to_stb", 32'(stb_cyc), 32'd16);
        check("to_lat", 32'(lat), 32'd17);
        check("to_flags", {30'h0, ea, eb}, 32'h1);
        check("to_rdata_kept", rdata, 32'h1122AA44);
        ack_en = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h18, 32'h0);
        check("post_to_load", rdata, 32'h01234567);
        check("post_to_flags", {30'h0, ea, eb}, 32'h0);

        // Asynchronous reset mid-read
        ack_en = 1'b0;
        poke(4'd4, 32'hDEADBEEF);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_stb", 32'(stb_o), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        @(negedge clk); rst_n = 1'b1; ack_en = 1'b1;
        run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("arst_load", rdata, 32'hDEADBEEF);
        check("arst_lat", 32'(lat), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Load/store bus master between the CPU memory stage and the word-wide data memory slave.
- Turns CPU byte, halfword and word load/store requests into single-word bus transactions on the stb/ack handshake.
- Sub-word stores are done as read-modify-write; loads are zero- or sign-extended.
- Reports misaligned accesses and a bus timeout back to the CPU.

Parameters:
- TIMEOUT, 16, max cycles stb may stay high without ack before a bus error is raised (range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  CPU request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- sext  in  1  sign-extend loaded byte/halfword.
- addr  in  32  CPU byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load result.
- done  out  1  one-cycle pulse when a request completes (ok or error).
- busy  out  1  high from the accepting edge until done.
- err_align  out  1  qualifies done: misaligned or reserved size.
- err_bus  out  1  qualifies done: ack timeout.
- dat_o  out  32  bus write data.
- adr_o  out  32  bus address, word aligned ({addr[31:2],2'b00}).
- we_o  out  1  bus write enable.
- stb_o  out  1  bus strobe.
- dat_i  in  32  bus read data, registered by the slave on the ack edge.
- ack_i  in  1  bus acknowledge.

Behaviour:
Reset (rst_n low, asynchronous):
- State IDLE.
- rdata, dat_o, adr_o = 0; we_o, stb_o, done, busy, err_align, err_bus = 0.
- Timeout counter = 0.

Byte lanes (little-endian):
- Byte offset k = addr[1:0] uses bits [8k+7:8k].
- A halfword uses bits [15:0] when addr[1]=0 and [31:16] when addr[1]=1.

States: IDLE, ALERR, RD, RDCAP, WR, FIN.
- IDLE:
  - On req, latch addr/we/size/sext/wdata and set busy.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0; size=11) → ALERR, with no bus activity.
  - Load or sub-word store → RD.
  - Word store → WR.
- ALERR: next cycle → FIN with err_align=1.
- RD:
  - stb_o=1, we_o=0, counter increments each cycle.
  - Rising edge with ack_i=1 → RDCAP.
  - Counter reaching TIMEOUT without ack → FIN with err_bus=1, stb_o dropped.
- RDCAP: dat_i is valid this cycle.
  - Load: extract lane, zero- or sign-extend into rdata → FIN.
  - Sub-word store: merge wdata's low byte/half into the captured word → dat_o → WR.
- WR:
  - stb_o=1, we_o=1, dat_o stable.
  - On ack edge → FIN; same timeout rule as RD.
- FIN:
  - done=1 for exactly one cycle; error flags are valid in the same cycle.
  - busy clears on the edge leaving FIN → IDLE.
  - rdata holds its value until the next load completes.
  - rdata is unchanged on stores and on errors.

Bus rules:
- stb_o is high only in RD and WR; it deasserts on the edge after ack is seen.
- adr_o and we_o are stable for the whole strobe.
- The counter clears on entry to RD and on entry to WR.

Latency with an immediate-ack slave:
- Load: 4 cycles, req edge to done.
- Word store: 3 cycles.
- Sub-word store: 5 cycles.
- Misaligned access: 3 cycles.

Boundary cases:
- req while busy is ignored.
- req held high across FIN starts a new request on the IDLE edge.
- ack_i outside RD/WR is ignored.
- rst_n asserted mid-transaction drops stb_o immediately; the memory may or may not have completed a write.

Test Plan:
- Word load: memory word at 0x10 = 0xDEADBEEF; req load word addr 0x10 → adr_o=0x10, stb_o for 1 cycle, done on cycle 4, rdata=0xDEADBEEF, no error flags.
- Signed and unsigned byte loads at addr 0x13, same word:
  - sext=1 → rdata=0xFFFFFFDE.
  - sext=0 → rdata=0x000000DE.
  - halfword at 0x10 with sext=1 → 0xFFFFBEEF.
- Byte store: wdata=0x000000AA to addr 0x11 (word 0x11223344) → one read then one write, dat_o=0x1122AA44, done on cycle 5; a re-read returns 0x1122AA44.
- Misalignment: word store to 0x12 → no stb_o ever, done with err_align=1 on cycle 3; memory unchanged.
- Timeout: ack_i tied low, TIMEOUT=16 → stb_o high for 16 cycles then drops, done with err_bus=1; next request proceeds normally.
- Async reset: rst_n pulsed low mid-RD with no clock edge → stb_o, busy, done go 0 immediately; post-reset word load returns correct data.
